// File: rtl/ecc_sram_scrub_wrap.sv
// ecc_sram_scrub_wrap: SECDED-protected single-port SRAM bank with RMW and write-back.
// Optional background scrubber is built when ECC_SRAM_SCRUB_EN is defined.
module ecc_sram_scrub_wrap #(
  parameter int unsigned BankSize = 256,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth = 16,
  parameter int unsigned ScrubInterval = 64,
  localparam int unsigned BankAddWidth = $clog2(BankSize),
  localparam int unsigned BeWidth = DataWidth / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [31:0]             addr_i,
  input  logic [BeWidth-1:0]      be_i,
  input  logic [DataWidth-1:0]    wdata_i,
  output logic                    rvalid_o,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    single_err_o,
  output logic                    multi_err_o,
  output logic [BankAddWidth-1:0] err_addr_o,
  output logic [CntWidth-1:0]     err_cnt_o,
  input  logic                    err_cnt_clr_i,
  input  logic                    scrub_en_i
);

  localparam int unsigned ProtectedWidth = (DataWidth == 64) ? 72 : 39;
  localparam int unsigned SynWidth = (DataWidth == 64) ? 7 : 6;
  localparam int unsigned AddrLsb = $clog2(BeWidth);

  if (DataWidth != 32 && DataWidth != 64) begin : g_bad_width
    $fatal(1, "ecc_sram_scrub_wrap: DataWidth must be 32 or 64");
  end

  typedef enum logic [1:0] {IDLE, READ, RMW, SCRUB} state_e;

  // Extended Hamming: bit 0 is overall parity, powers of two are check bits.
  function automatic logic [ProtectedWidth-1:0] encode(input logic [DataWidth-1:0] d);
    logic [ProtectedWidth-1:0] c;
    int unsigned j;
    c = '0;
    j = 0;
    for (int unsigned i = 1; i < ProtectedWidth; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    for (int unsigned p = 0; p < SynWidth; p++) begin
      for (int unsigned i = 1; i < ProtectedWidth; i++) begin
        if (i[p] && (i != (32'd1 << p))) c[32'd1 << p] ^= c[i];
      end
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [SynWidth-1:0] syndrome(input logic [ProtectedWidth-1:0] c);
    logic [SynWidth-1:0] s;
    s = '0;
    for (int unsigned i = 1; i < ProtectedWidth; i++) begin
      if (c[i]) s ^= SynWidth'(i);
    end
    return s;
  endfunction

  function automatic logic [DataWidth-1:0] extract(input logic [ProtectedWidth-1:0] c);
    logic [DataWidth-1:0] d;
    int unsigned j;
    d = '0;
    j = 0;
    for (int unsigned i = 1; i < ProtectedWidth; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  logic [ProtectedWidth-1:0] mem [BankSize];
  logic [ProtectedWidth-1:0] rdata_q, fixed, bank_wdata;
  logic [BankAddWidth-1:0]   addr_q, req_addr, bank_addr, scrub_addr;
  logic [BeWidth-1:0]        be_q;
  logic [DataWidth-1:0]      wdata_q, dec_data, merged, enc_in;
  logic [CntWidth-1:0]       cnt_q;
  logic [SynWidth-1:0]       syn;
  state_e state_q, state_d;
  logic err_single, err_multi, chk, gnt, rvalid, accept;
  logic bank_req, bank_we, scrub_due;
  logic full_wr, part_wr, rd;
  logic unused_addr;

  assign req_addr = addr_i[BankAddWidth+AddrLsb-1:AddrLsb];
  assign unused_addr = ^{addr_i[31:BankAddWidth+AddrLsb], addr_i[AddrLsb-1:0]};

  assign syn = syndrome(rdata_q);
  assign err_single = ^rdata_q;
  assign err_multi = !(^rdata_q) && (syn != '0);

  always_comb begin
    fixed = rdata_q;
    if (err_single && syn != '0 && 32'(syn) < ProtectedWidth) fixed[syn] = ~fixed[syn];
  end

  assign dec_data = extract(fixed);

  always_comb begin
    merged = dec_data;
    for (int b = 0; b < BeWidth; b++) begin
      if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  assign full_wr = req_i && we_i && (&be_i);
  assign part_wr = req_i && we_i && !(&be_i);
  assign rd = req_i && !we_i;

  always_comb begin
    state_d = state_q;
    gnt = 1'b0;
    rvalid = 1'b0;
    chk = 1'b0;
    accept = 1'b0;
    bank_req = 1'b0;
    bank_we = 1'b0;
    bank_addr = req_addr;
    enc_in = wdata_i;
    unique case (state_q)
      IDLE: accept = 1'b1;
      READ: begin
        rvalid = 1'b1;
        chk = 1'b1;
        if (err_single) begin
          bank_req = 1'b1;
          bank_we = 1'b1;
          bank_addr = addr_q;
          enc_in = dec_data;
          state_d = IDLE;
        end else begin
          accept = 1'b1;
        end
      end
      RMW: begin
        chk = 1'b1;
        bank_req = 1'b1;
        bank_we = 1'b1;
        bank_addr = addr_q;
        enc_in = merged;
        state_d = IDLE;
      end
      SCRUB: begin
        chk = 1'b1;
        state_d = IDLE;
        if (err_single) begin
          bank_req = 1'b1;
          bank_we = 1'b1;
          bank_addr = scrub_addr;
          enc_in = dec_data;
        end
      end
    endcase
    if (accept) begin
      gnt = 1'b1;
      state_d = IDLE;
      unique case (1'b1)
        full_wr: begin
          bank_req = 1'b1;
          bank_we = 1'b1;
        end
        part_wr: begin
          bank_req = 1'b1;
          state_d = RMW;
        end
        rd: begin
          bank_req = 1'b1;
          state_d = READ;
        end
        scrub_due: begin
          bank_req = 1'b1;
          bank_addr = scrub_addr;
          state_d = SCRUB;
        end
        default: ;
      endcase
    end
    bank_wdata = encode(enc_in);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_i && gnt) begin
        addr_q <= req_addr;
        be_q <= be_i;
        wdata_q <= wdata_i;
      end
      if (bank_req && !bank_we) rdata_q <= mem[bank_addr];
      if (err_cnt_clr_i) cnt_q <= '0;
      else if (chk && err_single && cnt_q != '1) cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && bank_req && bank_we) mem[bank_addr] <= bank_wdata;
  end

`ifdef ECC_SRAM_SCRUB_EN
  localparam int unsigned TimerWidth = $clog2(ScrubInterval + 1);
  logic [TimerWidth-1:0]   timer_q;
  logic [BankAddWidth-1:0] scrub_addr_q;
  logic                    scrub_tick;

  assign scrub_tick = (state_q == IDLE) && !req_i && scrub_en_i;
  assign scrub_due = scrub_tick && (timer_q == TimerWidth'(ScrubInterval - 1));
  assign scrub_addr = scrub_addr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timer_q <= '0;
      scrub_addr_q <= '0;
    end else begin
      if (scrub_due) timer_q <= '0;
      else if (scrub_tick) timer_q <= timer_q + TimerWidth'(1);
      if (state_q == SCRUB) begin
        scrub_addr_q <= (scrub_addr_q == BankAddWidth'(BankSize - 1)) ?
                        '0 : scrub_addr_q + BankAddWidth'(1);
      end
    end
  end
`else
  logic unused_scrub;
  assign scrub_due = 1'b0;
  assign scrub_addr = '0;
  assign unused_scrub = scrub_en_i;
`endif

  assign gnt_o = rst_ni & gnt;
  assign rvalid_o = rst_ni & rvalid;
  assign rdata_o = (rst_ni && rvalid) ? dec_data : '0;
  assign single_err_o = rst_ni & chk & err_single;
  assign multi_err_o = rst_ni & chk & err_multi;
  assign err_addr_o = !rst_ni ? '0 : (state_q == SCRUB) ? scrub_addr : addr_q;
  assign err_cnt_o = rst_ni ? cnt_q : '0;

endmodule

// File: tb/tb_ecc_sram_scrub_wrap.sv
// Scoreboard bench for ecc_sram_scrub_wrap: random traffic plus injected bit flips.
// Scrub checks are compiled in when ECC_SRAM_SCRUB_EN is defined.
module tb_ecc_sram_scrub_wrap;
`ifdef ECC_SRAM_SCRUB_EN
  localparam int BS = 8;
  localparam int SI = 4;
`else
  localparam int BS = 256;
  localparam int SI = 64;
`endif
  localparam int AW = $clog2(BS);
  localparam int NW = (BS < 32) ? BS : 32;

  logic clk = 0, rst_n = 0, req = 0, we = 0, clr = 0, scrub_en = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] be = 0;
  logic gnt, rvalid, single_err, multi_err;
  logic [31:0] rdata;
  logic [AW-1:0] err_addr;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  ecc_sram_scrub_wrap #(
    .BankSize(BS), .DataWidth(32), .CntWidth(16), .ScrubInterval(SI)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we),
    .addr_i(addr), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid),
    .rdata_o(rdata), .single_err_o(single_err), .multi_err_o(multi_err),
    .err_addr_o(err_addr), .err_cnt_o(err_cnt), .err_cnt_clr_i(clr),
    .scrub_en_i(scrub_en)
  );

  typedef struct {
    logic [31:0] data;
    bit single;
    bit multi;
    int word;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic [31:0] model [BS];
  int flips [BS];
  int exp_cnt = 0;
  int checks = 0, fails = 0;
  bit bare_ok = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        if (q.size() == 0) check("rvalid_unexpected", 64'(rvalid), 0);
        else begin
          e = q.pop_front();
          if (!e.multi) check("rdata", 64'(rdata), 64'(e.data));
          check("single_err", 64'(single_err), 64'(e.single));
          check("multi_err", 64'(multi_err), 64'(e.multi));
          check("gnt_in_read", 64'(gnt), 64'(!e.single));
          if (e.single || e.multi) check("err_addr", 64'(err_addr), 64'(e.word));
        end
      end else if (!bare_ok && (single_err || multi_err)) begin
        check("bare_err", {62'd0, single_err, multi_err}, 0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(bit w, int word, logic [3:0] b, logic [31:0] d);
    int n;
    exp_t x;
    req = 1;
    we = w;
    addr = 32'(word) << 2;
    be = b;
    wdata = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (gnt) begin
        if (w) begin
          for (int k = 0; k < 4; k++) if (b[k]) model[word][8*k +: 8] = d[8*k +: 8];
          flips[word] = 0;
        end else begin
          x.data = model[word];
          x.single = (flips[word] == 1);
          x.multi = (flips[word] >= 2);
          x.word = word;
          q.push_back(x);
          if (flips[word] == 1) begin
            flips[word] = 0;
            exp_cnt++;
          end
        end
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      n++;
      if (n > 50) begin
        check("gnt_timeout", 64'(gnt), 1);
        break;
      end
    end
  endtask

  task automatic idle(int n);
    req = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    req = 0;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 64'(q.size()), 0);
    idle(2);
  endtask

  task automatic flip(int word, int b);
    dut.mem[word][b] = ~dut.mem[word][b];
    flips[word]++;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_gnt"}, 64'(gnt), 0);
    check({tag, "_rvalid"}, 64'(rvalid), 0);
    check({tag, "_errs"}, {62'd0, single_err, multi_err}, 0);
    check({tag, "_rdata"}, 64'(rdata), 0);
    check({tag, "_erraddr"}, 64'(err_addr), 0);
    check({tag, "_cnt"}, 64'(err_cnt), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, r;
    logic [31:0] old;
    bit seen;
    for (int i = 0; i < BS; i++) flips[i] = 0;
    req = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1;
    req = 0;
    for (int i = 0; i < NW; i++) issue(1, i, 4'hF, $urandom);
    // Full write, then read with one-cycle latency
    issue(1, 4, 4'hF, 32'hDEADBEEF);
    issue(0, 4, 4'h0, 32'h0);
    req = 0;
    @(negedge clk);
    check("read_latency", 64'(rvalid), 1);
    @(posedge clk);
    #1;
    // Partial write stalls one cycle
    issue(1, 4, 4'b0011, 32'h00001234);
    req = 0;
    @(negedge clk);
    check("rmw_gnt_low", 64'(gnt), 0);
    @(posedge clk);
    #1;
    issue(0, 4, 4'h0, 32'h0);
    drain();
    // Single flip: corrected and written back
    flip(4, 7);
    issue(0, 4, 4'h0, 32'h0);
    drain();
    check("cnt_single", 64'(err_cnt), 64'(exp_cnt));
    issue(0, 4, 4'h0, 32'h0);
    drain();
    // Double flip: detected, not repaired
    flip(4, 3);
    flip(4, 20);
    issue(0, 4, 4'h0, 32'h0);
    drain();
    check("cnt_multi", 64'(err_cnt), 64'(exp_cnt));
    issue(0, 4, 4'h0, 32'h0);
    drain();
    issue(1, 4, 4'hF, 32'h0BADF00D);
    // Clear in the same cycle as a single error
    flip(5, 1);
    issue(0, 5, 4'h0, 32'h0);
    req = 0;
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
    exp_cnt = 0;
    drain();
    check("cnt_clear", 64'(err_cnt), 64'(exp_cnt));
    // Random traffic
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      w = $urandom_range(0, NW - 1);
      if (r <= 3) issue(0, w, 4'h0, 32'h0);
      else if (r <= 5) issue(1, w, 4'hF, $urandom);
      else if (r <= 7) issue(1, w, 4'($urandom % 16), $urandom);
      else if (r == 8) begin
        drain();
        flip(w, $urandom_range(0, 38));
        issue(0, w, 4'h0, 32'h0);
      end else idle($urandom_range(0, 2));
    end
    drain();
    check("cnt_random", 64'(err_cnt), 64'(exp_cnt));
    // Reset during RMW drops the write
    old = model[6];
    issue(1, 6, 4'b1100, 32'hA5A5A5A5);
    req = 0;
    rst_n = 0;
    @(negedge clk);
    check_zero("rmw_reset");
    @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("rmw_reset2");
    @(posedge clk);
    #1;
    rst_n = 1;
    model[6] = old;
    exp_cnt = 0;
    issue(0, 6, 4'h0, 32'h0);
    drain();
`ifdef ECC_SRAM_SCRUB_EN
    flip(3, 5);
    bare_ok = 1;
    scrub_en = 1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (single_err) begin
        seen = 1;
        check("scrub_err_addr", 64'(err_addr), 3);
      end
      @(posedge clk);
      #1;
    end
    scrub_en = 0;
    idle(3);
    bare_ok = 0;
    check("scrub_seen", 64'(seen), 1);
    flips[3] = 0;
    exp_cnt++;
    check("scrub_cnt", 64'(err_cnt), 64'(exp_cnt));
    issue(0, 3, 4'h0, 32'h0);
    drain();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
